// File: rtl/lut_cfg_if.sv
//------------------------------------------------------------------------------
// lut_cfg_if : config-load and evaluation signals of lut_cfg_ctrl
// Revision   : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lut_cfg_if #(
   parameter int NUM_LUTS = 4
);
   logic                    start_i;
   logic                    cfg_valid_i;
   logic                    cfg_ready_o;
   logic [15:0]             cfg_data_i;
   logic                    cfg_par_i;
   logic                    lut_valid_i;
   logic [4*NUM_LUTS-1:0]   lut_i;
   logic                    lut_valid_o;
   logic [NUM_LUTS-1:0]     lut_o;
   logic                    busy_o;
   logic                    done_o;
   logic                    err_o;

   modport master (
      output start_i, cfg_valid_i, cfg_data_i, cfg_par_i, lut_valid_i, lut_i,
      input  cfg_ready_o, lut_valid_o, lut_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, cfg_valid_i, cfg_data_i, cfg_par_i, lut_valid_i, lut_i,
      output cfg_ready_o, lut_valid_o, lut_o, busy_o, done_o, err_o
   );
endinterface

`default_nettype wire

// File: rtl/lut_cfg_ctrl.sv
//------------------------------------------------------------------------------
// lut_cfg_ctrl : loads NUM_LUTS 16-entry truth tables and evaluates them.
// Optional parity checking on config words: define LUT_CFG_PARITY_EN.
// Revision     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lut_cfg_ctrl #(
   parameter int NUM_LUTS = 4
) (
   input  wire logic clk_i,
   input  wire logic rst_i,
   lut_cfg_if.slave  bus
);

   localparam int CNT_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
   localparam logic [CNT_W-1:0] C_LAST_WORD = CNT_W'(NUM_LUTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic                 w_wr_en;
   logic                 w_hs;
   logic                 w_par_err;
   logic [NUM_LUTS-1:0]  w_eval;
   logic                 w_eval_en;
   logic                 r_lut_valid;
   logic [NUM_LUTS-1:0]  r_lut;

`ifdef LUT_CFG_PARITY_EN
   assign w_par_err = ^{bus.cfg_data_i, bus.cfg_par_i};
`else
   logic w_unused_par;
   assign w_unused_par = bus.cfg_par_i;
   assign w_par_err    = 1'b0;
`endif

   assign w_hs      = bus.cfg_valid_i && (r_state == ST_LOAD);
   assign w_eval_en = bus.lut_valid_i && (r_state == ST_RUN);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // start_i wins over a handshake on the same edge; that word is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wr_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start_i) begin
               w_state_nxt = ST_LOAD;
               w_cnt_nxt   = '0;
            end
         end
         ST_LOAD: begin
            if (bus.start_i) begin
               w_cnt_nxt = '0;
            end else if (w_hs) begin
               if (w_par_err) begin
                  w_state_nxt = ST_ERR;
               end else begin
                  w_wr_en = 1'b1;
                  if (r_cnt == C_LAST_WORD) begin
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_W'(1);
                  end
               end
            end
         end
         ST_RUN, ST_ERR: begin
            if (bus.start_i) begin
               w_state_nxt = ST_LOAD;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // One table register per LUT, each owning its own evaluation mux.
   for (genvar k = 0; k < NUM_LUTS; k++) begin : g_table
      logic [15:0] r_word;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_word <= '0;
         end else if (w_wr_en && (r_cnt == CNT_W'(k))) begin
            r_word <= bus.cfg_data_i;
         end
      end

      assign w_eval[k] = r_word[bus.lut_i[4*k +: 4]];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lut_valid <= 1'b0;
         r_lut       <= '0;
      end else begin
         r_lut_valid <= w_eval_en;
         if (w_eval_en) begin
            r_lut <= w_eval;
         end
      end
   end

   assign bus.cfg_ready_o = (r_state == ST_LOAD);
   assign bus.busy_o      = (r_state == ST_LOAD);
   assign bus.done_o      = (r_state == ST_RUN);
   assign bus.lut_valid_o = r_lut_valid;
   assign bus.lut_o       = r_lut;
`ifdef LUT_CFG_PARITY_EN
   assign bus.err_o       = (r_state == ST_ERR);
`else
   assign bus.err_o       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_cfg_ctrl.sv
//------------------------------------------------------------------------------
// tb_lut_cfg_ctrl : randomized self-checking bench for lut_cfg_ctrl
// Revision        : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lut_cfg_ctrl;

   localparam int L = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   logic [15:0]  mdl [L];
   logic [L-1:0] exp_lut;

   lut_cfg_if #(.NUM_LUTS(L)) bus ();

   lut_cfg_ctrl #(.NUM_LUTS(L)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [L-1:0] mdl_eval(input logic [4*L-1:0] idx);
      logic [L-1:0] r;
      for (int k = 0; k < L; k++) begin
         logic [15:0] t;
         t    = mdl[k];
         r[k] = t[idx[4*k +: 4]];
      end
      return r;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      n_checks++;
      if ({bus.busy_o, bus.cfg_ready_o, bus.done_o, bus.err_o} !== 4'b1100)
         $display("FAIL start: busy/ready/done/err got %b expected 1100",
                  {bus.busy_o, bus.cfg_ready_o, bus.done_o, bus.err_o});
      else n_pass++;
   endtask

   task automatic load_set(input logic [15:0] w [L]);
      for (int i = 0; i < L; i++) begin
         bus.cfg_valid_i = 1'b1;
         bus.cfg_data_i  = w[i];
         bus.cfg_par_i   = ^w[i];
         step();
         mdl[i] = w[i];
         if (i < L - 1) begin
            n_checks++;
            if ({bus.busy_o, bus.done_o} !== 2'b10)
               $display("FAIL load_busy: word %0d busy/done got %b expected 10",
                        i, {bus.busy_o, bus.done_o});
            else n_pass++;
         end
      end
      bus.cfg_valid_i = 1'b0;
      n_checks++;
      if ({bus.done_o, bus.busy_o, bus.cfg_ready_o} !== 3'b100)
         $display("FAIL load_done: done/busy/ready got %b expected 100",
                  {bus.done_o, bus.busy_o, bus.cfg_ready_o});
      else n_pass++;
   endtask

   task automatic verify_tables(input string name);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] n;
         n = 4'(i);
         bus.lut_valid_i = 1'b1;
         bus.lut_i       = {L{n}};
         step();
         exp_lut = mdl_eval({L{n}});
         n_checks++;
         if ({bus.lut_valid_o, bus.lut_o} !== {1'b1, exp_lut})
            $display("FAIL %s: index %0d valid/lut got %b expected %b",
                     name, i, {bus.lut_valid_o, bus.lut_o}, {1'b1, exp_lut});
         else n_pass++;
      end
      bus.lut_valid_i = 1'b0;
      step();
   endtask

   task automatic test_reset;
      rst             = 1'b1;
      bus.start_i     = 1'b0;
      bus.cfg_valid_i = 1'b0;
      bus.cfg_data_i  = '0;
      bus.cfg_par_i   = 1'b0;
      bus.lut_valid_i = 1'b0;
      bus.lut_i       = '0;
      #3;
      n_checks++;
      if ({bus.cfg_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.lut_valid_o, bus.lut_o} !== '0)
         $display("FAIL reset_outputs: got %b expected 0",
                  {bus.cfg_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.lut_valid_o, bus.lut_o});
      else n_pass++;
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < L; k++) mdl[k] = '0;
      exp_lut = '0;
      step();
      n_checks++;
      if ({bus.cfg_ready_o, bus.busy_o, bus.done_o} !== 3'b000)
         $display("FAIL idle_after_reset: got %b expected 000",
                  {bus.cfg_ready_o, bus.busy_o, bus.done_o});
      else n_pass++;
   endtask

   task automatic test_directed;
      logic [15:0] w [L];
      w = '{16'h8000, 16'hFFFE, 16'h6996, 16'h0001};
      pulse_start();
      load_set(w);
      bus.lut_valid_i = 1'b1;
      bus.lut_i       = 16'h777F;
      step();
      bus.lut_valid_i = 1'b0;
      exp_lut = 4'b0111;
      n_checks++;
      if ({bus.lut_valid_o, bus.lut_o} !== {1'b1, exp_lut})
         $display("FAIL eval_777f: got %b expected %b",
                  {bus.lut_valid_o, bus.lut_o}, {1'b1, exp_lut});
      else n_pass++;
      step();
      n_checks++;
      if ({bus.lut_valid_o, bus.lut_o} !== {1'b0, exp_lut})
         $display("FAIL eval_hold: got %b expected %b",
                  {bus.lut_valid_o, bus.lut_o}, {1'b0, exp_lut});
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [15:0] w [L];
      for (int i = 0; i < L; i++) w[i] = 16'($urandom);
      pulse_start();
      load_set(w);
      for (int c = 0; c < 60; c++) begin
         logic       v;
         logic [4*L-1:0] idx;
         v   = ($urandom_range(0, 3) != 0);
         idx = (4*L)'($urandom);
         bus.lut_valid_i = v;
         bus.lut_i       = idx;
         step();
         if (v) exp_lut = mdl_eval(idx);
         n_checks++;
         if ({bus.lut_valid_o, bus.lut_o} !== {v, exp_lut})
            $display("FAIL back_to_back: cycle %0d got %b expected %b",
                     c, {bus.lut_valid_o, bus.lut_o}, {v, exp_lut});
         else n_pass++;
      end
      bus.lut_valid_i = 1'b0;
      step();
   endtask

   task automatic test_outside_run;
      pulse_start();
      bus.lut_valid_i = 1'b1;
      bus.lut_i       = (4*L)'($urandom);
      step();
      bus.lut_valid_i = 1'b0;
      n_checks++;
      if ({bus.lut_valid_o, bus.lut_o} !== {1'b0, exp_lut})
         $display("FAIL eval_in_load: got %b expected %b",
                  {bus.lut_valid_o, bus.lut_o}, {1'b0, exp_lut});
      else n_pass++;
   endtask

   task automatic test_toggle;
      logic [15:0] w [L];
      int          i;
      for (int k = 0; k < L; k++) w[k] = 16'($urandom);
      pulse_start();
      i = 0;
      for (int c = 0; c < 4 * L && i < L; c++) begin
         bus.cfg_valid_i = (c % 2 == 0);
         bus.cfg_data_i  = bus.cfg_valid_i ? w[i] : 16'($urandom);
         bus.cfg_par_i   = ^bus.cfg_data_i;
         step();
         if (bus.cfg_valid_i) begin
            mdl[i] = w[i];
            i++;
         end
      end
      bus.cfg_valid_i = 1'b0;
      n_checks++;
      if ({bus.done_o, bus.busy_o} !== 2'b10)
         $display("FAIL toggle_done: got %b expected 10", {bus.done_o, bus.busy_o});
      else n_pass++;
      verify_tables("toggle_tables");
   endtask

   task automatic test_restart;
      logic [15:0] w [L];
      for (int k = 0; k < L; k++) w[k] = 16'($urandom);
      pulse_start();
      bus.cfg_valid_i = 1'b1;
      bus.cfg_data_i  = 16'($urandom);
      bus.cfg_par_i   = ^bus.cfg_data_i;
      step();
      bus.start_i     = 1'b1;
      bus.cfg_data_i  = 16'($urandom);
      bus.cfg_par_i   = ^bus.cfg_data_i;
      step();
      bus.start_i     = 1'b0;
      bus.cfg_valid_i = 1'b0;
      n_checks++;
      if ({bus.busy_o, bus.cfg_ready_o, bus.done_o} !== 3'b110)
         $display("FAIL restart_state: got %b expected 110",
                  {bus.busy_o, bus.cfg_ready_o, bus.done_o});
      else n_pass++;
      load_set(w);
      verify_tables("restart_tables");
   endtask

   task automatic test_parity;
      logic [15:0] w [L];
      for (int k = 0; k < L; k++) w[k] = 16'($urandom);
      pulse_start();
      bus.cfg_valid_i = 1'b1;
      bus.cfg_data_i  = w[0];
      bus.cfg_par_i   = ^w[0];
      step();
      bus.cfg_data_i  = 16'h0001;
      bus.cfg_par_i   = 1'b0;
      step();
      bus.cfg_valid_i = 1'b0;
`ifdef LUT_CFG_PARITY_EN
      n_checks++;
      if ({bus.err_o, bus.cfg_ready_o, bus.busy_o, bus.done_o} !== 4'b1000)
         $display("FAIL parity_err: err/ready/busy/done got %b expected 1000",
                  {bus.err_o, bus.cfg_ready_o, bus.busy_o, bus.done_o});
      else n_pass++;
      step();
      n_checks++;
      if (bus.err_o !== 1'b1)
         $display("FAIL parity_err_sticky: got %b expected 1", bus.err_o);
      else n_pass++;
      pulse_start();
      load_set(w);
      verify_tables("parity_reload");
`else
      // Without parity checking the bad-parity word is an ordinary write.
      mdl[0] = w[0];
      mdl[1] = 16'h0001;
      n_checks++;
      if ({bus.err_o, bus.busy_o} !== 2'b01)
         $display("FAIL parity_ignored: err/busy got %b expected 01",
                  {bus.err_o, bus.busy_o});
      else n_pass++;
      for (int i = 2; i < L; i++) begin
         bus.cfg_valid_i = 1'b1;
         bus.cfg_data_i  = w[i];
         bus.cfg_par_i   = ~(^w[i]);
         step();
         mdl[i] = w[i];
      end
      bus.cfg_valid_i = 1'b0;
      n_checks++;
      if ({bus.done_o, bus.err_o} !== 2'b10)
         $display("FAIL parity_ignored_done: done/err got %b expected 10",
                  {bus.done_o, bus.err_o});
      else n_pass++;
      verify_tables("parity_ignored_tables");
`endif
   endtask

   task automatic test_reset_mid;
      logic [15:0] w [L];
      for (int k = 0; k < L; k++) w[k] = 16'hFFFF;
      pulse_start();
      load_set(w);
      bus.lut_valid_i = 1'b1;
      bus.lut_i       = (4*L)'($urandom);
      step();
      exp_lut = '1;
      n_checks++;
      if (bus.lut_o !== exp_lut)
         $display("FAIL pre_reset_eval: got %b expected %b", bus.lut_o, exp_lut);
      else n_pass++;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.cfg_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.lut_valid_o, bus.lut_o} !== '0)
         $display("FAIL reset_mid_eval: got %b expected 0",
                  {bus.cfg_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.lut_valid_o, bus.lut_o});
      else n_pass++;
      bus.lut_valid_i = 1'b0;
      step();
      rst = 1'b0;
      for (int k = 0; k < L; k++) mdl[k] = '0;
      exp_lut = '0;

      pulse_start();
      bus.cfg_valid_i = 1'b1;
      bus.cfg_data_i  = 16'h5A5A;
      bus.cfg_par_i   = ^bus.cfg_data_i;
      step();
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.cfg_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.lut_valid_o, bus.lut_o} !== '0)
         $display("FAIL reset_mid_load: got %b expected 0",
                  {bus.cfg_ready_o, bus.busy_o, bus.done_o, bus.err_o, bus.lut_valid_o, bus.lut_o});
      else n_pass++;
      step();
      bus.cfg_valid_i = 1'b0;
      rst = 1'b0;
      step();

      for (int k = 0; k < L; k++) w[k] = 16'h0000;
      pulse_start();
      load_set(w);
      bus.lut_valid_i = 1'b1;
      bus.lut_i       = 16'hFFFF;
      step();
      bus.lut_valid_i = 1'b0;
      exp_lut = '0;
      n_checks++;
      if ({bus.lut_valid_o, bus.lut_o} !== {1'b1, exp_lut})
         $display("FAIL eval_zero_ffff: got %b expected %b",
                  {bus.lut_valid_o, bus.lut_o}, {1'b1, exp_lut});
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_outside_run();
      test_toggle();
      test_restart();
      test_parity();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
